// File: rtl/pb_input_decoder.sv
// Push-button front end: two-flop synchronizer, tick-paced per-button debounce,
// and a highest-index priority encoder with one-cycle press/release strobes.
module pb_input_decoder #(
  parameter int TICK_DIV = 100000,
  parameter int DEB_LEN  = 4
) (
  input  logic        hwclk,
  input  logic        n_rst,
  input  logic [14:0] pb,
  output logic [14:0] btn_db,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        press,
  // "release" is a reserved word in SystemVerilog, so the strobe is key_release
  output logic        key_release
);

  localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [DEB_LEN-1:0] HIST_ONES = '1;
  localparam logic [DEB_LEN-1:0] HIST_ZERO = '0;

  logic [14:0]        pb_p0;
  logic [14:0]        pb_p1;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [DEB_LEN-1:0] hist       [15];
  logic [DEB_LEN-1:0] hist_shift [15];
  logic [14:0]        db_nxt;
  logic [3:0]         key_nxt;

  function automatic logic [3:0] encode_key(input logic [14:0] b);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (b[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

  // Stage p0/p1: metastability synchronizer, pb_p1 is the synchronized level
  always_ff @(posedge hwclk) begin
    if (!n_rst) begin
      pb_p0 <= '0;
      pb_p1 <= '0;
    end else begin
      pb_p0 <= pb;
      pb_p1 <= pb_p0;
    end
  end

  assign tick = (tick_cnt == CNT_MAX);

  always_ff @(posedge hwclk) begin
    if (!n_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Stage p2: debounce histories, level changes only on a full run of equal samples
  always_comb begin
    db_nxt = btn_db;
    for (int i = 0; i < 15; i++) begin
      hist_shift[i] = {hist[i][DEB_LEN-2:0], pb_p1[i]};
      if (hist_shift[i] == HIST_ONES) begin
        db_nxt[i] = 1'b1;
      end else if (hist_shift[i] == HIST_ZERO) begin
        db_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (!n_rst) begin
      for (int i = 0; i < 15; i++) hist[i] <= '0;
      btn_db <= '0;
    end else if (tick) begin
      for (int i = 0; i < 15; i++) hist[i] <= hist_shift[i];
      btn_db <= db_nxt;
    end
  end

  // Stage p3: registered key code and edge strobes derived from the code change
  assign key_nxt = encode_key(btn_db);

  always_ff @(posedge hwclk) begin
    if (!n_rst) begin
      key         <= 4'd0;
      key_valid   <= 1'b0;
      press       <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key         <= key_nxt;
      key_valid   <= (key_nxt != 4'd0);
      press       <= (key_nxt != 4'd0) && (key_nxt != key);
      key_release <= (key_nxt == 4'd0) && (key != 4'd0);
    end
  end

endmodule
